// File: rtl/sprite_fetch_sched.sv
// -----------------------------------------------------------------------------
// sprite_fetch_sched
//
// Purpose:
//   Shares the sprite pattern ROMs (plane, chopper, battleship) among NSPR
//   sprite slots. On every line_start (start of hblank) it latches the sprite
//   registers and the scanline to prepare. It then walks the slots one by one.
//   For each slot that covers that scanline, it streams one SPR_SIZE-pixel row
//   from the selected ROM into that slot's line buffer. The pixel mux later
//   reads the line buffers instead of addressing the ROMs per pixel.
//
// Optional feature (macro SPRITE_FETCH_MIRROR_EN):
//   When defined, a slot whose latched spr_flip bit is set is fetched
//   mirrored: the ROM column is SPR_SIZE-1-col while lb_col stays ascending.
//   When undefined, spr_flip is ignored.
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous active-high reset
//   line_start in   one-cycle pulse at start of hblank
//   next_line  in   scanline to prepare (vcount+1, already wrapped)
//   spr_y      in   per slot {centre row[9:1], enable[0]}, slot 0 in LSBs
//   spr_img    in   per slot ROM select (0 plane, 1 chopper, 2 battleship)
//   spr_flip   in   per slot horizontal mirror request
//   rom_sel    out  ROM targeted by rom_addr
//   rom_addr   out  ROM address {row, col}; rom_q is valid one clock later
//   rom_q      in   muxed ROM read data
//   lb_we      out  line-buffer write strobe
//   lb_slot    out  line buffer being written
//   lb_col     out  column being written
//   lb_data    out  pixel being written
//   slot_hit   out  per slot "sprite present on prepared line"
//   busy       out  high from acceptance of line_start until done
//   done       out  one-cycle pulse when all slots are processed
//   overrun    out  sticky flag: line_start arrived while the scheduler was busy
// -----------------------------------------------------------------------------
module sprite_fetch_sched #(
    parameter int NSPR     = 3,
    parameter int SPR_SIZE = 32,
    parameter int ADDR_W   = 10,
    parameter int PIX_W    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 line_start,
    input  logic [9:0]           next_line,
    input  logic [NSPR*10-1:0]   spr_y,
    input  logic [NSPR*2-1:0]    spr_img,
    input  logic [NSPR-1:0]      spr_flip,
    output logic [1:0]           rom_sel,
    output logic [ADDR_W-1:0]    rom_addr,
    input  logic [PIX_W-1:0]     rom_q,
    output logic                 lb_we,
    output logic [1:0]           lb_slot,
    output logic [4:0]           lb_col,
    output logic [PIX_W-1:0]     lb_data,
    output logic [NSPR-1:0]      slot_hit,
    output logic                 busy,
    output logic                 done,
    output logic                 overrun
);

    localparam int          COL_W  = $clog2(SPR_SIZE);
    localparam logic [10:0] HALF11 = 11'(SPR_SIZE / 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_FETCH,
        S_DRAIN,
        S_FIN
    } state_t;

    state_t state_q, state_d;

    // Copies taken at line_start; the live register inputs are ignored while busy.
    logic [NSPR*10-1:0] y_q;
    logic [NSPR*2-1:0]  img_q;
    logic [NSPR-1:0]    flip_q;
    logic [9:0]         line_q;

    logic [1:0]         slot_q;
    logic [COL_W-1:0]   col_q;
    logic [COL_W-1:0]   row_q;
    logic [NSPR-1:0]    acc_q;
    logic [NSPR-1:0]    slot_hit_q;
    logic               busy_q;
    logic               overrun_q;
    logic               lb_we_q;
    logic [1:0]         lb_slot_q;
    logic [COL_W-1:0]   lb_col_q;

    // Per-slot hit test and row offset, evaluated on the latched copies.
    logic [NSPR-1:0]            hit_w;
    logic [NSPR-1:0][COL_W-1:0] row_w;
    logic [NSPR-1:0][1:0]       img_w;
    logic [NSPR-1:0]            flip_w;
    logic [10:0]                line11;

    assign line11 = {1'b0, line_q};

    generate
        for (genvar gi = 0; gi < NSPR; gi++) begin : g_slot
            logic [10:0] cy11;
            logic [10:0] diff11;
            logic        en;

            assign cy11   = {2'b00, y_q[gi*10+1 +: 9]};
            assign en     = y_q[gi*10];
            assign img_w[gi]  = img_q[gi*2 +: 2];
            assign flip_w[gi] = flip_q[gi];
            // The sprite is biased by half its height so that the
            // comparison never goes negative for centres near row 0.
            assign diff11 = line11 + HALF11 - cy11;
            assign hit_w[gi] = en && (img_w[gi] != 2'd3) &&
                               (line11 + HALF11 >= cy11) &&
                               (line11 < cy11 + HALF11);
            assign row_w[gi] = diff11[COL_W-1:0];
        end
    endgenerate

    logic             cur_hit;
    logic [COL_W-1:0] cur_row;
    logic [1:0]       cur_img;
    logic             cur_flip;
    logic             last_slot;
    logic             last_col;

    assign cur_hit   = hit_w[slot_q];
    assign cur_row   = row_w[slot_q];
    assign cur_img   = img_w[slot_q];
    assign cur_flip  = flip_w[slot_q];
    assign last_slot = (slot_q == 2'(NSPR - 1));
    assign last_col  = (col_q == COL_W'(SPR_SIZE - 1));

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (line_start) state_d = S_CHECK;
            S_CHECK: begin
                if (cur_hit)        state_d = S_FETCH;
                else if (last_slot) state_d = S_FIN;
                else                state_d = S_CHECK;
            end
            S_FETCH: if (last_col) state_d = S_DRAIN;
            S_DRAIN: state_d = last_slot ? S_FIN : S_CHECK;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    logic [COL_W-1:0] col_eff;

`ifdef SPRITE_FETCH_MIRROR_EN
    // SPR_SIZE is a power of two, so SPR_SIZE-1-col is the bitwise inverse.
    assign col_eff = cur_flip ? ~col_q : col_q;
`else
    logic unused_flip;
    assign unused_flip = cur_flip;
    assign col_eff     = col_q;
`endif

    always_comb begin
        rom_sel  = 2'd0;
        rom_addr = '0;
        done     = 1'b0;
        case (state_q)
            S_FETCH: begin
                rom_sel  = cur_img;
                rom_addr = {row_q, col_eff};
            end
            S_FIN:   done = 1'b1;
            default: ;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            y_q        <= '0;
            img_q      <= '0;
            flip_q     <= '0;
            line_q     <= '0;
            slot_q     <= '0;
            col_q      <= '0;
            row_q      <= '0;
            acc_q      <= '0;
            slot_hit_q <= '0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
            lb_we_q    <= 1'b0;
            lb_slot_q  <= '0;
            lb_col_q   <= '0;
        end else begin
            // The write trails the address by one clock to match ROM latency.
            lb_we_q   <= (state_q == S_FETCH);
            lb_slot_q <= (state_q == S_FETCH) ? slot_q : 2'd0;
            lb_col_q  <= (state_q == S_FETCH) ? col_q  : '0;

            if (line_start && (state_q != S_IDLE)) begin
                overrun_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (line_start) begin
                        y_q    <= spr_y;
                        img_q  <= spr_img;
                        flip_q <= spr_flip;
                        line_q <= next_line;
                        slot_q <= '0;
                        acc_q  <= '0;
                        busy_q <= 1'b1;
                    end
                end
                S_CHECK: begin
                    if (cur_hit) begin
                        row_q         <= cur_row;
                        col_q         <= '0;
                        acc_q[slot_q] <= 1'b1;
                    end else begin
                        acc_q[slot_q] <= 1'b0;
                        if (!last_slot) slot_q <= slot_q + 2'd1;
                    end
                end
                S_FETCH: begin
                    col_q <= col_q + 1'b1;
                end
                S_DRAIN: begin
                    if (!last_slot) slot_q <= slot_q + 2'd1;
                end
                S_FIN: begin
                    slot_hit_q <= acc_q;
                    busy_q     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign lb_we    = lb_we_q;
    assign lb_slot  = lb_slot_q;
    assign lb_col   = 5'(lb_col_q);
    assign lb_data  = lb_we_q ? rom_q : '0;
    assign slot_hit = slot_hit_q;
    assign busy     = busy_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_sprite_fetch_sched.sv
module tb_sprite_fetch_sched;

    localparam int NSPR = 3;

    logic               clk = 1'b0;
    logic               reset;
    logic               line_start;
    logic [9:0]         next_line;
    logic [NSPR*10-1:0] spr_y;
    logic [NSPR*2-1:0]  spr_img;
    logic [NSPR-1:0]    spr_flip;
    logic [1:0]         rom_sel;
    logic [9:0]         rom_addr;
    logic [3:0]         rom_q;
    logic               lb_we;
    logic [1:0]         lb_slot;
    logic [4:0]         lb_col;
    logic [3:0]         lb_data;
    logic [NSPR-1:0]    slot_hit;
    logic               busy;
    logic               done;
    logic               overrun;

    always #10 clk = ~clk;

    sprite_fetch_sched dut (
        .clk        (clk),
        .reset      (reset),
        .line_start (line_start),
        .next_line  (next_line),
        .spr_y      (spr_y),
        .spr_img    (spr_img),
        .spr_flip   (spr_flip),
        .rom_sel    (rom_sel),
        .rom_addr   (rom_addr),
        .rom_q      (rom_q),
        .lb_we      (lb_we),
        .lb_slot    (lb_slot),
        .lb_col     (lb_col),
        .lb_data    (lb_data),
        .slot_hit   (slot_hit),
        .busy       (busy),
        .done       (done),
        .overrun    (overrun)
    );

    // Synthetic ROM contents, one clock read latency.
    function automatic logic [3:0] rom_fn(input int sel, input int addr);
        int t;
        t = addr * 7 + sel * 101 + (addr >> 5);
        return 4'(t ^ (t >> 4));
    endfunction

    always @(posedge clk) rom_q <= rom_fn(int'(rom_sel), int'(rom_addr));

    int vectors    = 0;
    int miscompares = 0;
    bit exp_ovr    = 1'b0;

    typedef struct {
        int slot;
        int col;
        int addr;
        int sel;
        int data;
    } wr_t;

    wr_t exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic set_slot(input int s, input int cy, input bit en, input int img, input bit flip);
        spr_y[s*10 +: 10] = {9'(cy), en};
        spr_img[s*2 +: 2] = 2'(img);
        spr_flip[s]       = flip;
    endtask

    task automatic clear_slots();
        spr_y    = '0;
        spr_img  = '0;
        spr_flip = '0;
    endtask

    // One scanline preparation: builds the expected write list from the
    // sprite geometry, then watches the DUT until done (bounded).
    task automatic run_line(input int nl, input int inject_at);
        int          sum;
        logic [2:0]  hits;
        int          exp_done;
        int          prev_addr;
        int          prev_sel;
        bit          got_done;
        wr_t         e;

        sum  = 0;
        hits = '0;
        exp_q.delete();
        for (int s = 0; s < NSPR; s++) begin
            int cy, img, diff, row;
            bit en, flip;
            cy   = int'(spr_y[s*10+1 +: 9]);
            en   = spr_y[s*10];
            img  = int'(spr_img[s*2 +: 2]);
            flip = spr_flip[s];
            diff = nl - cy;
            if (en && img != 3 && diff >= -16 && diff < 16) begin
                hits[s] = 1'b1;
                row     = diff + 16;
                sum    += 34;
                for (int c = 0; c < 32; c++) begin
                    int ac;
                    ac = c;
`ifdef SPRITE_FETCH_MIRROR_EN
                    if (flip) ac = 31 - c;
`else
                    if (flip) ac = c;
`endif
                    e.slot = s;
                    e.col  = c;
                    e.addr = row * 32 + ac;
                    e.sel  = img;
                    e.data = int'(rom_fn(img, row * 32 + ac));
                    exp_q.push_back(e);
                end
            end else begin
                sum += 1;
            end
        end
        exp_done = 1 + sum;

        @(negedge clk);
        next_line  = 10'(nl);
        line_start = 1'b1;
        prev_addr  = 0;
        prev_sel   = 0;
        got_done   = 1'b0;
        for (int cyc = 1; cyc <= 300 && !got_done; cyc++) begin
            @(negedge clk);
            if (cyc == 1) chk("busy_on", busy, 1);
            if (lb_we) begin
                if (exp_q.size() == 0) begin
                    chk("extra_write", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("lb_slot", lb_slot, e.slot);
                    chk("lb_col",  lb_col,  e.col);
                    chk("lb_data", lb_data, e.data);
                    chk("rom_addr", prev_addr, e.addr);
                    chk("rom_sel",  prev_sel,  e.sel);
                end
            end
            if (done) begin
                got_done = 1'b1;
                chk("done_cycle", cyc, exp_done);
                chk("writes_left", exp_q.size(), 0);
            end
            prev_addr  = int'(rom_addr);
            prev_sel   = int'(rom_sel);
            line_start = (cyc == inject_at);
            if (cyc == inject_at) exp_ovr = 1'b1;
            // Live register changes mid-line must not disturb the fetch.
            if (cyc == 5) begin
                spr_y     = {$urandom, $urandom};
                spr_img   = 6'($urandom);
                spr_flip  = 3'($urandom);
                next_line = 10'($urandom);
            end
        end
        if (!got_done) chk("done_timeout", 0, 1);
        @(negedge clk);
        line_start = 1'b0;
        chk("slot_hit", slot_hit, hits);
        chk("busy_off", busy, 0);
        chk("done_off", done, 0);
        chk("lb_we_off", lb_we, 0);
        chk("overrun", overrun, exp_ovr);
        $display("line nl=%0d hits=%b done_at=%0d overrun=%0b", nl, hits, exp_done, exp_ovr);
    endtask

    initial begin
        reset      = 1'b1;
        line_start = 1'b0;
        next_line  = '0;
        clear_slots();
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_lb_we", lb_we, 0);
        chk("rst_slot_hit", slot_hit, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_rom_sel", rom_sel, 0);
        chk("rst_lb_col", lb_col, 0);
        chk("rst_lb_slot", lb_slot, 0);
        chk("rst_lb_data", lb_data, 0);
        reset = 1'b0;

        // Basic single-slot fetch: row 6, addresses 192..223.
        clear_slots();
        set_slot(0, 240, 1'b1, 0, 1'b0);
        run_line(230, 0);

        // Edge rows around cy=240.
        clear_slots();
        set_slot(0, 240, 1'b1, 1, 1'b0);
        run_line(224, 0);
        clear_slots();
        set_slot(0, 240, 1'b1, 1, 1'b0);
        run_line(256, 0);
        clear_slots();
        set_slot(0, 240, 1'b1, 1, 1'b0);
        run_line(255, 0);

        // Small centres near the top of the screen, and the invalid ROM code.
        clear_slots();
        set_slot(0, 5, 1'b1, 2, 1'b0);
        run_line(0, 0);
        clear_slots();
        set_slot(0, 5, 1'b1, 2, 1'b0);
        run_line(21, 0);
        clear_slots();
        set_slot(0, 100, 1'b1, 3, 1'b0);
        run_line(100, 0);

        // All slots hit, with a second line_start while busy.
        clear_slots();
        set_slot(0, 300, 1'b1, 0, 1'b0);
        set_slot(1, 310, 1'b1, 1, 1'b0);
        set_slot(2, 290, 1'b1, 2, 1'b0);
        run_line(300, 50);

        // Reset in the middle of a fetch.
        clear_slots();
        set_slot(0, 240, 1'b1, 0, 1'b0);
        @(negedge clk);
        next_line  = 10'd230;
        line_start = 1'b1;
        for (int cyc = 1; cyc <= 11; cyc++) begin
            @(negedge clk);
            line_start = 1'b0;
            if (cyc == 11) reset = 1'b1;
        end
        @(negedge clk);
        chk("midrst_lb_we", lb_we, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_slot_hit", slot_hit, 0);
        chk("midrst_overrun", overrun, 0);
        chk("midrst_done", done, 0);
        $display("reset mid-fetch applied");
        exp_ovr = 1'b0;
        reset   = 1'b0;
        clear_slots();
        set_slot(0, 240, 1'b1, 0, 1'b0);
        run_line(230, 0);

        // line_start coincident with the FIN cycle.
        clear_slots();
        set_slot(0, 240, 1'b1, 0, 1'b0);
        run_line(230, 37);

        // Flip request on row 0.
        clear_slots();
        set_slot(0, 240, 1'b1, 0, 1'b1);
        run_line(224, 0);

        // Randomised lines clustered so that hits are common.
        for (int it = 0; it < 25; it++) begin
            int base;
            int inj;
            base = int'($urandom_range(0, 600));
            clear_slots();
            for (int s = 0; s < NSPR; s++) begin
                int cyv;
                cyv = base + int'($urandom_range(0, 48)) - 24;
                if (cyv < 0)   cyv = 0;
                if (cyv > 511) cyv = 511;
                set_slot(s, cyv, ($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
                         1'($urandom_range(0, 1)));
            end
            inj = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 40)) : 0;
            run_line(base, inj);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sprite_fetch_sched.md
Name: sprite_fetch_sched

Overview:
- Scheduler that shares the sprite pattern ROMs (plane, chopper, battleship) among NSPR sprite slots.
- During horizontal blanking it checks each slot against the next scanline. For each hit it fetches one 32-pixel row from the selected ROM into the per-slot line buffer.
- Sits between the Avalon sprite registers / VGA counters and the pixel mux. The mux then reads line buffers instead of addressing ROMs combinationally per pixel.

Parameters:
- NSPR, 3, number of sprite slots.
- SPR_SIZE, 32, sprite width/height in pixels (power of two).
- ADDR_W, 10, ROM address width = 2*log2(SPR_SIZE).
- PIX_W, 4, colour index width.

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  synchronous, active-high reset.
- line_start  in  1  one-cycle pulse at start of hblank (hcount==1280).
- next_line  in  10  scanline to prepare (vcount+1, wrapped by caller).
- spr_y  in  NSPR*10  per slot: [9:1] centre row, [0] enable; slot 0 in LSBs.
- spr_img  in  NSPR*2  per slot ROM select: 0 plane, 1 chopper, 2 battleship, 3 invalid.
- spr_flip  in  NSPR  per slot horizontal mirror (used only with the optional feature).
- rom_sel  out  2  which ROM the current address targets.
- rom_addr  out  ADDR_W  ROM address; ROM q valid one clk later.
- rom_q  in  PIX_W  muxed ROM data.
- lb_we  out  1  line-buffer write strobe.
- lb_slot  out  2  line buffer (slot) being written.
- lb_col  out  5  column written.
- lb_data  out  PIX_W  pixel written.
- slot_hit  out  NSPR  per-slot "sprite present on prepared line".
- busy  out  1  high from accept of line_start until done.
- done  out  1  one-cycle pulse when all slots processed.
- overrun  out  1  sticky: line_start arrived while busy.

Behaviour:
- Reset: FSM=IDLE; every output 0; internal slot/col/row counters 0; latched copies 0.
- States: IDLE, CHECK, FETCH, DRAIN, FIN.
- IDLE
  - On line_start: latch spr_y, spr_img, spr_flip, next_line.
  - slot<=0, hit accumulator<=0, busy<=1, go CHECK.
- CHECK (1 cycle per slot)
  - cy = latched y[9:1]. Compare in 11-bit unsigned: hit iff enable && img!=3 && next_line+16 >= cy && next_line < cy+16. This avoids underflow for cy<16.
  - Hit: row = (next_line+16-cy)[4:0], col<=0, set hit bit, go FETCH.
  - Miss: clear hit bit. If slot==NSPR-1 go FIN, else slot++ and stay in CHECK.
- FETCH (SPR_SIZE cycles)
  - Each cycle: rom_sel=img, rom_addr={row,col}, col++.
  - One cycle later: lb_we=1, lb_slot=slot, lb_col=issued col, lb_data=rom_q.
  - After col 31 is issued go DRAIN.
- DRAIN (1 cycle)
  - Writes the pixel for col 31.
  - Then next slot to CHECK, or FIN if slot==NSPR-1.
- FIN (1 cycle)
  - slot_hit<=accumulator (updates only here); done=1, busy<=0, go IDLE.
- Latency: line_start to done = NSPR*(1+SPR_SIZE+1)+2 cycles worst case (104 for defaults). Must be ≤ hblank (320 clk).
- lb_we is never asserted outside FETCH+1 and DRAIN. Exactly SPR_SIZE writes per hit slot, cols strictly ascending (0..31).
- Register changes during busy have no effect (latched copies used).
- line_start while busy: ignored, overrun<=1 (stays set until reset).
- line_start coincident with FIN: ignored, overrun set.
- Reset mid-fetch: immediate return to IDLE, partial line discarded, slot_hit=0.
- next_line wrap: no special case. Rows ≥480 simply produce no hits for cy ≤ 463.

Optional Feature:
- Macro SPRITE_FETCH_MIRROR_EN.
- Defined: for slots with latched spr_flip=1, rom_addr column = 31-col while lb_col stays ascending, giving a horizontally mirrored row.
- Undefined: spr_flip is ignored; addressing is always {row,col}.

Test Plan:
- Slot0 y={240,1}, img=0, next_line=230, others disabled; line_start → rom_addr 6*32+0..31 (192..223), rom_sel=0, 32 lb_we with lb_slot=0; done at cycle 38 (1 accept + 34 slot0 + 2 misses + 1 FIN); slot_hit=3'b001.
- Edge rows: cy=240, next_line=224 → hit, row 0; next_line=256 → miss; next_line=255 → row 31 (addr 992..1023).
- Underflow: cy=5, next_line=0 → hit, row 11; cy=5, next_line=21 → miss; img=3 with enable=1 → miss.
- All three slots hit → 96 writes in slot order 0,1,2; done 104 cycles after line_start; second line_start at cycle 50 → ignored, overrun=1, fetch unaffected.
- Reset asserted at cycle 10 of FETCH → next cycle lb_we=0, busy=0, slot_hit=0; a following line_start fetches normally.
- With SPRITE_FETCH_MIRROR_EN, flip=1, row 0 → rom_addr 31,30..0 while lb_col 0..31; with the macro undefined, same stimulus gives rom_addr 0..31.
